// File: rtl/cr_tlvp_ob_arb.sv
// cr_tlvp_ob_arb: outbound TLV arbiter merging the pt and usr TLV FIFOs into one downstream write port
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   pt_ib_empty/tlv/rd       pt FIFO: empty flag, show-ahead head word, pop
//   usr_ib_empty/tlv/rd      usr FIFO: empty flag, show-ahead head word, pop
//   ob_afull                 downstream almost-full (asserts with >=2 free entries)
//   ob_wen/wdata/src         registered downstream write (src: 0 = pt, 1 = usr)
//   pt_tlv_cnt, usr_tlv_cnt  saturating counts of forwarded TLVs per source
//
// Grants are TLV-atomic. Between TLVs a weighted round-robin picks the source,
// and each TLV costs one arbitration cycle in IDLE.
package cr_tlvp_pkg;
    typedef struct packed {
        logic        sot;
        logic        eot;
        logic [31:0] data;
    } tlvp_if_bus_t;
endpackage

module cr_tlvp_ob_arb
    import cr_tlvp_pkg::*;
#(
    parameter int USR_WEIGHT = 2,
    parameter int PT_WEIGHT  = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pt_ib_empty,
    input  tlvp_if_bus_t     pt_ib_tlv,
    output logic             pt_ib_rd,
    input  logic             usr_ib_empty,
    input  tlvp_if_bus_t     usr_ib_tlv,
    output logic             usr_ib_rd,
    input  logic             ob_afull,
    output logic             ob_wen,
    output tlvp_if_bus_t     ob_wdata,
    output logic             ob_src,
    output logic [CNT_W-1:0] pt_tlv_cnt,
    output logic [CNT_W-1:0] usr_tlv_cnt
);
    typedef enum logic [1:0] {IDLE, PT_XFER, USR_XFER} state_t;

    state_t     state;
    logic       last_grant;
    logic       fresh;
    logic       grant;
    logic       both;
    logic       any;
    logic [3:0] wt_cnt;
    logic [3:0] hold_lim;

    // fresh marks "no grant since reset": the reset value of last_grant is usr,
    // and pt must win the very first tie rather than usr being re-granted.
    always_comb begin
        pt_ib_rd  = (state == PT_XFER) && !pt_ib_empty && !ob_afull;
        usr_ib_rd = (state == USR_XFER) && !usr_ib_empty && !ob_afull;
        both      = !pt_ib_empty && !usr_ib_empty;
        any       = !pt_ib_empty || !usr_ib_empty;
        hold_lim  = last_grant ? 4'(USR_WEIGHT - 1) : 4'(PT_WEIGHT - 1);
        grant     = both ? ((!fresh && wt_cnt < hold_lim) ? last_grant : !last_grant) : !usr_ib_empty;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            fresh       <= 1'b1;
            wt_cnt      <= 4'd0;
            ob_wen      <= 1'b0;
            ob_src      <= 1'b0;
            ob_wdata    <= '0;
            pt_tlv_cnt  <= '0;
            usr_tlv_cnt <= '0;
        end else begin
            ob_wen <= pt_ib_rd | usr_ib_rd;
            if (pt_ib_rd | usr_ib_rd) begin
                ob_wdata <= usr_ib_rd ? usr_ib_tlv : pt_ib_tlv;
                ob_src   <= usr_ib_rd;
            end
            if (pt_ib_rd && pt_ib_tlv.eot && pt_tlv_cnt != '1)
                pt_tlv_cnt <= pt_tlv_cnt + CNT_W'(1);
            if (usr_ib_rd && usr_ib_tlv.eot && usr_tlv_cnt != '1)
                usr_tlv_cnt <= usr_tlv_cnt + CNT_W'(1);
            case (state)
                IDLE: begin
                    if (any) begin
                        state      <= grant ? USR_XFER : PT_XFER;
                        // wt_cnt saturates so a long run of lone grants cannot wrap it
                        wt_cnt     <= (grant == last_grant) ? ((wt_cnt == 4'hf) ? wt_cnt : wt_cnt + 4'd1) : 4'd0;
                        last_grant <= grant;
                        fresh      <= 1'b0;
                    end
                end
                PT_XFER:  if (pt_ib_rd && pt_ib_tlv.eot) state <= IDLE;
                USR_XFER: if (usr_ib_rd && usr_ib_tlv.eot) state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    a_one_hot_rd: assert property (@(posedge clk) disable iff (rst) !(pt_ib_rd && usr_ib_rd));
    a_no_empty_pop: assert property (@(posedge clk) disable iff (rst)
        !(pt_ib_rd && pt_ib_empty) && !(usr_ib_rd && usr_ib_empty));
endmodule

// File: tb/tb_cr_tlvp_ob_arb.sv
// tb_cr_tlvp_ob_arb: directed and randomized checks of cr_tlvp_ob_arb against a TLV-level WRR model
module tb_cr_tlvp_ob_arb;
    import cr_tlvp_pkg::*;

    localparam int UW = 2;
    localparam int PW = 1;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pt_ib_empty = 1'b1;
    tlvp_if_bus_t  pt_ib_tlv = '0;
    logic          pt_ib_rd;
    logic          usr_ib_empty = 1'b1;
    tlvp_if_bus_t  usr_ib_tlv = '0;
    logic          usr_ib_rd;
    logic          ob_afull = 1'b0;
    logic          ob_wen;
    tlvp_if_bus_t  ob_wdata;
    logic          ob_src;
    logic [CW-1:0] pt_tlv_cnt;
    logic [CW-1:0] usr_tlv_cnt;

    cr_tlvp_ob_arb #(.USR_WEIGHT(UW), .PT_WEIGHT(PW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .pt_ib_empty(pt_ib_empty), .pt_ib_tlv(pt_ib_tlv), .pt_ib_rd(pt_ib_rd),
        .usr_ib_empty(usr_ib_empty), .usr_ib_tlv(usr_ib_tlv), .usr_ib_rd(usr_ib_rd),
        .ob_afull(ob_afull), .ob_wen(ob_wen), .ob_wdata(ob_wdata), .ob_src(ob_src),
        .pt_tlv_cnt(pt_tlv_cnt), .usr_tlv_cnt(usr_tlv_cnt)
    );

    always #5 clk = ~clk;

    tlvp_if_bus_t pt_q[$], usr_q[$], m_pt[$], m_usr[$];
    logic [34:0]  exp_q[$];
    logic         wen_log[$], src_log[$];
    tlvp_if_bus_t held;
    int           n_cmp = 0, n_err = 0, m_last = -1, m_run = 0, np = 0, nu = 0;
    logic         pt_gate = 0, usr_gate = 0, afull_drv = 0, log_en = 0;
    logic         prd = 0, urd = 0, wen_s = 0, last_pop = 0, last_usr_eot = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic src, input int len);
        tlvp_if_bus_t w;
        for (int i = 0; i < len; i++) begin
            w.sot  = (i == 0);
            w.eot  = (i == len - 1);
            w.data = $urandom;
            if (src) begin
                usr_q.push_back(w);
                m_usr.push_back(w);
            end else begin
                pt_q.push_back(w);
                m_pt.push_back(w);
            end
        end
    endtask

    // TLV-level reference: the run length of the last granted source against its weight
    // decides ties; a lone pending source always wins. Produces the expected word stream.
    task automatic model_build();
        logic g;
        tlvp_if_bus_t w;
        while (m_pt.size() > 0 || m_usr.size() > 0) begin
            if (m_pt.size() > 0 && m_usr.size() > 0) begin
                if (m_last < 0) g = 1'b0;
                else if (m_run < (m_last == 1 ? UW : PW)) g = m_last[0];
                else g = ~m_last[0];
            end else g = (m_usr.size() > 0);
            m_run  = (m_last == int'(g)) ? m_run + 1 : 1;
            m_last = int'(g);
            do begin
                if (g) w = m_usr.pop_front();
                else w = m_pt.pop_front();
                exp_q.push_back({g, w});
            end while (!w.eot);
            if (g) nu++;
            else np++;
        end
    endtask

    task automatic cycle();
        logic [34:0] e;
        pt_ib_empty  = pt_gate || pt_q.size() == 0;
        pt_ib_tlv    = (pt_q.size() > 0) ? pt_q[0] : '0;
        usr_ib_empty = usr_gate || usr_q.size() == 0;
        usr_ib_tlv   = (usr_q.size() > 0) ? usr_q[0] : '0;
        ob_afull     = afull_drv;
        @(negedge clk);
        prd   = pt_ib_rd;
        urd   = usr_ib_rd;
        wen_s = ob_wen;
        if (!rst) begin
            chk("wen_latency", ob_wen, last_pop);
            if (afull_drv) chk("pop_under_afull", prd | urd, 0);
            if (log_en) begin
                wen_log.push_back(ob_wen);
                if (ob_wen) src_log.push_back(ob_src);
            end
            if (ob_wen) begin
                if (exp_q.size() == 0) chk("extra_wen", ob_wen, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("word", {ob_src, ob_wdata}, e);
                    held = e[33:0];
                end
            end else chk("wdata_hold", ob_wdata, held);
        end
        @(posedge clk);
        #1;
        last_usr_eot = usr_ib_tlv.eot;
        if (prd) void'(pt_q.pop_front());
        if (urd) void'(usr_q.pop_front());
        last_pop = prd | urd;
    endtask

    task automatic reset_hold();
        rst = 1'b1;
        pt_q.delete(); usr_q.delete(); m_pt.delete(); m_usr.delete(); exp_q.delete();
        wen_log.delete(); src_log.delete();
        m_last = -1; m_run = 0; np = 0; nu = 0; held = '0; last_pop = 0;
        pt_gate = 0; usr_gate = 0; afull_drv = 0;
    endtask

    task automatic do_reset();
        reset_hold();
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic drain(input bit rnd);
        int n = 0;
        while ((pt_q.size() > 0 || usr_q.size() > 0 || exp_q.size() > 0) && n < 1000) begin
            afull_drv = rnd && ($urandom_range(0, 3) == 0);
            cycle();
            n++;
        end
        afull_drv = 0;
        cycle(); cycle(); cycle();
        chk("words_left", exp_q.size(), 0);
        chk("pt_tlv_cnt", pt_tlv_cnt, np > 15 ? 15 : np);
        chk("usr_tlv_cnt", usr_tlv_cnt, nu > 15 ? 15 : nu);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, cnt, pops, n;
        logic [4:0] pat;
        logic [5:0] ord;
        logic gated;

        // reset with both FIFOs holding data
        reset_hold();
        push(0, 1);
        push(1, 1);
        cycle();
        cycle();
        chk("rst_ob_wen", ob_wen, 0);
        chk("rst_ob_src", ob_src, 0);
        chk("rst_ob_wdata", ob_wdata, 0);
        chk("rst_pt_cnt", pt_tlv_cnt, 0);
        chk("rst_usr_cnt", usr_tlv_cnt, 0);
        chk("rst_pops", {pt_ib_rd, usr_ib_rd}, 0);
        rst = 1'b0;
        model_build();
        log_en = 1;
        drain(0);
        log_en = 0;
        chk("first_grant_src", (src_log.size() > 0) ? src_log[0] : 1'bx, 0);

        // pt only: 3-word then 1-word TLV
        do_reset();
        push(0, 3);
        push(0, 1);
        model_build();
        log_en = 1;
        drain(0);
        log_en = 0;
        k = -1;
        for (int i = 0; i < wen_log.size(); i++) if (k < 0 && wen_log[i]) k = i;
        pat = '0;
        for (int i = 0; i < 5; i++) if (k >= 0 && k + i < wen_log.size()) pat[4-i] = wen_log[k+i];
        chk("pt_only_wen_pattern", pat, 5'b11101);
        for (int i = 0; i < src_log.size(); i++) chk("pt_only_src", src_log[i], 0);

        // both backlogged with 1-word TLVs: pt, usr, usr, pt, usr, usr
        do_reset();
        for (int i = 0; i < 6; i++) begin
            push(0, 1);
            push(1, 1);
        end
        model_build();
        log_en = 1;
        drain(0);
        log_en = 0;
        ord = '0;
        for (int i = 0; i < 6; i++) if (i < src_log.size()) ord[5-i] = src_log[i];
        chk("wrr_order", ord, 6'b011011);

        // usr FIFO runs dry mid-TLV for 5 cycles while pt is pending
        do_reset();
        push(0, 1);
        push(1, 3);
        push(0, 1);
        model_build();
        gated = 0;
        n = 0;
        while ((pt_q.size() > 0 || usr_q.size() > 0 || exp_q.size() > 0) && n < 200) begin
            cycle();
            n++;
            if (!gated && urd && !last_usr_eot) begin
                usr_gate = 1;
                for (int i = 0; i < 5; i++) begin
                    cycle();
                    chk("gap_pt_pop", prd, 0);
                end
                usr_gate = 0;
                gated = 1;
            end
        end
        chk("gap_applied", gated, 1);
        drain(0);

        // ob_afull held for 4 cycles mid-TLV
        do_reset();
        push(0, 6);
        model_build();
        pops = 0;
        for (int i = 0; i < 20 && pops < 2; i++) begin
            cycle();
            pops += int'(prd);
        end
        afull_drv = 1;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            cnt += int'(wen_s);
        end
        afull_drv = 0;
        cycle();
        cnt += int'(wen_s);
        chk("afull_inflight_wen", cnt, 1);
        drain(0);

        // counter saturation, then reset mid-TLV
        do_reset();
        for (int i = 0; i < 20; i++) push(0, 1);
        model_build();
        drain(0);
        chk("pt_cnt_saturated", pt_tlv_cnt, 15);
        push(0, 4);
        model_build();
        pops = 0;
        for (int i = 0; i < 20 && pops < 1; i++) begin
            cycle();
            pops += int'(prd);
        end
        rst = 1'b1;
        #1;
        chk("midtlv_rst_pt_cnt", pt_tlv_cnt, 0);
        chk("midtlv_rst_usr_cnt", usr_tlv_cnt, 0);
        chk("midtlv_rst_wen", ob_wen, 0);
        chk("midtlv_rst_rd", {pt_ib_rd, usr_ib_rd}, 0);

        // randomized backlogs with random ob_afull, second round keeps arbiter history
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < int'($urandom_range(3, 8)); i++) push(0, int'($urandom_range(1, 4)));
            for (int i = 0; i < int'($urandom_range(3, 8)); i++) push(1, int'($urandom_range(1, 4)));
            model_build();
            drain(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
